axi_m2s_mn: RTL and testbench
=============================

# axi_m2s_mn

Parametrised N-master to 1-slave AXI request-path multiplexer: decodes each master's AW/AR address against the slave window, arbitrates AW and AR independently with registered round-robin grants, and routes W beats in AW-acceptance order through an internal write-order queue. It sits in front of each slave port of the interconnect and supersedes the fixed 3-master mux that needed an externally supplied write-order grant. Response channels (B/R) are out of scope.

## Interface
- NUM_MASTER, 4, number of master ports (2..8)
- W_MIDX, 2, master-index width, ≥ clog2(NUM_MASTER)
- ADDR_BASE, 32'h0, slave window base
- ADDR_LENGTH, 12, decoded offset bits; match on ADDR[W_ADDR-1:ADDR_LENGTH]
- W_ID, 4, master ID width
- W_ADDR, 32, address width
- W_DATA, 32, data width
- W_STRB, W_DATA/8, strobe width
- W_SID, W_MIDX+W_ID, slave-side ID width
- WQ_DEPTH, 4, write-order queue entries, power of 2, ≥2

Ports (M_* buses flattened, master i in slice i):
- AXI_CLK  in  1  clock
- AXI_RSTn  in  1  asynchronous active-low reset
- M_AWID/M_WID/M_ARID  in  NUM_MASTER*W_ID  master IDs
- M_AWADDR/M_ARADDR  in  NUM_MASTER*W_ADDR  addresses
- M_AWLEN/M_ARLEN  in  NUM_MASTER*8; M_AWSIZE/M_ARSIZE  in  NUM_MASTER*3; M_AWBURST/M_ARBURST  in  NUM_MASTER*2  burst attributes
- M_AWVALID/M_ARVALID/M_WVALID/M_WLAST  in  NUM_MASTER  per-master strobes
- M_WDATA  in  NUM_MASTER*W_DATA; M_WSTRB  in  NUM_MASTER*W_STRB  write data
- M_AWREADY/M_WREADY/M_ARREADY  out  NUM_MASTER  per-master ready
- S_AWID/S_WID/S_ARID  out  W_SID  {master index, master ID}
- S_AWADDR, S_AWLEN, S_AWSIZE, S_AWBURST, S_AWVALID  out  widths as above; S_AWREADY in 1
- S_WDATA, S_WSTRB, S_WLAST, S_WVALID  out; S_WREADY in 1
- S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST, S_ARVALID  out; S_ARREADY in 1
- WQ_FULL  out  1  write-order queue full

## Operation
- Request i on AW (AR): M_AWVALID[i] & address hit. Non-hitting masters never granted.
- AW arbiter states IDLE/LOCKED; registers grant index g and priority pointer p. IDLE: if any request and (AW only) queue not full, pick first requester scanning p, p+1, … mod NUM_MASTER; register g, go LOCKED.
- LOCKED: S_AW* = master g fields, S_AWVALID = M_AWVALID[g], M_AWREADY[g] = S_AWREADY; others 0. Grant held until S_AWVALID & S_AWREADY; then push g into queue, p ← g+1 mod NUM_MASTER, return IDLE.
- AR arbiter identical, own pointer, no queue gating, no push.
- W: queue empty → S_WVALID=0, all M_WREADY=0. Else head h: S_W* = master h fields, S_WID = {h, M_WID[h]}, S_WVALID = M_WVALID[h], M_WREADY[h] = S_WREADY. Pop on S_WVALID & S_WREADY & S_WLAST.
- No bypass: a W beat is forwarded only once its AW index is at the queue head.
- Simultaneous push and pop: count unchanged, both take effect. Full: AW IDLE grants nothing (pop same cycle does not unblock until next cycle). Pointer wrap mod WQ_DEPTH.
- Idle outputs: all S_* fields driven 0 when not granted / queue empty.

## Timing
- Reset (async assert, sync deassert-safe): arbiters IDLE, p=0, queue empty; S_AWVALID/S_WVALID/S_ARVALID=0, all M_*READY=0, all S_* fields 0, WQ_FULL=0.
- AW/AR latency: request in cycle n → S_xVALID in n+1. Handshake cycle m → next grant earliest m+1 IDLE, S_xVALID at m+2. Back-to-back bandwidth: one address per 2 cycles per channel.
- W: AW handshake cycle m → first W beat of that burst forwardable in m+1. Beats within burst zero-bubble; next burst's first beat forwardable cycle after WLAST pop.
- Fields stable while LOCKED and S_xVALID & !S_xREADY (inherits master stability).
- WQ_FULL registered, reflects count==WQ_DEPTH.

## Test plan
- Reset mid-burst: assert AXI_RSTn=0 during LOCKED AW and W beat 2 of 4 → all valids/readies 0 same cycle, queue empty, p=0 after release.
- Round-robin: masters 0,1,3 (NUM_MASTER=4) hold AWVALID, S_AWREADY=1 → S_AWID index order 0,1,3,0 on cycles 1,3,5,7.
- Backpressure: S_AWREADY=0 for 5 cycles with master 2 granted, master 0 requesting → grant stays 2, S_AWADDR unchanged, then 0 granted after handshake.
- Write order: AW from master 1 then master 0, masters present W in opposite order → S_WID index 1 burst (len 3, 4 beats) fully before index 0 burst; M_WREADY[0]=0 meanwhile.
- Queue full: WQ_DEPTH=4, 4 AWs accepted, no W → WQ_FULL=1, 5th AW not granted; one WLAST pop → 5th S_AWVALID appears 2 cycles later.
- Decode: master 2 AWADDR outside window (ADDR_BASE=32'h1000, addr 32'h2000) → never granted, M_AWREADY[2]=0; ARADDR 32'h1FFC hits and is granted.

Source files
------------

// File: rtl/axi_m2s_mn_if.sv
// axi_m2s_mn_if: bundle between N AXI masters and one slave port.
// Master buses are flattened, with master i in slice i.
interface axi_m2s_mn_if #(
  parameter int NUM_MASTER = 4,
  parameter int W_MIDX     = 2,
  parameter int W_ID       = 4,
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int W_STRB     = W_DATA/8,
  parameter int W_SID      = W_MIDX+W_ID
) ();
  logic [NUM_MASTER*W_ID-1:0]   M_AWID;
  logic [NUM_MASTER*W_ADDR-1:0] M_AWADDR;
  logic [NUM_MASTER*8-1:0]      M_AWLEN;
  logic [NUM_MASTER*3-1:0]      M_AWSIZE;
  logic [NUM_MASTER*2-1:0]      M_AWBURST;
  logic [NUM_MASTER-1:0]        M_AWVALID;
  logic [NUM_MASTER-1:0]        M_AWREADY;

  logic [NUM_MASTER*W_ID-1:0]   M_WID;
  logic [NUM_MASTER*W_DATA-1:0] M_WDATA;
  logic [NUM_MASTER*W_STRB-1:0] M_WSTRB;
  logic [NUM_MASTER-1:0]        M_WLAST;
  logic [NUM_MASTER-1:0]        M_WVALID;
  logic [NUM_MASTER-1:0]        M_WREADY;

  logic [NUM_MASTER*W_ID-1:0]   M_ARID;
  logic [NUM_MASTER*W_ADDR-1:0] M_ARADDR;
  logic [NUM_MASTER*8-1:0]      M_ARLEN;
  logic [NUM_MASTER*3-1:0]      M_ARSIZE;
  logic [NUM_MASTER*2-1:0]      M_ARBURST;
  logic [NUM_MASTER-1:0]        M_ARVALID;
  logic [NUM_MASTER-1:0]        M_ARREADY;

  logic [W_SID-1:0]  S_AWID;
  logic [W_ADDR-1:0] S_AWADDR;
  logic [7:0]        S_AWLEN;
  logic [2:0]        S_AWSIZE;
  logic [1:0]        S_AWBURST;
  logic              S_AWVALID;
  logic              S_AWREADY;

  logic [W_SID-1:0]  S_WID;
  logic [W_DATA-1:0] S_WDATA;
  logic [W_STRB-1:0] S_WSTRB;
  logic              S_WLAST;
  logic              S_WVALID;
  logic              S_WREADY;

  logic [W_SID-1:0]  S_ARID;
  logic [W_ADDR-1:0] S_ARADDR;
  logic [7:0]        S_ARLEN;
  logic [2:0]        S_ARSIZE;
  logic [1:0]        S_ARBURST;
  logic              S_ARVALID;
  logic              S_ARREADY;

  logic              WQ_FULL;

  modport slave (
    input  M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE,
    input  M_AWBURST, M_AWVALID,
    input  M_WID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    input  M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE,
    input  M_ARBURST, M_ARVALID,
    input  S_AWREADY, S_WREADY, S_ARREADY,
    output M_AWREADY, M_WREADY, M_ARREADY,
    output S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE,
    output S_AWBURST, S_AWVALID,
    output S_WID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    output S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE,
    output S_ARBURST, S_ARVALID,
    output WQ_FULL
  );

  modport master (
    output M_AWID, M_AWADDR, M_AWLEN, M_AWSIZE,
    output M_AWBURST, M_AWVALID,
    output M_WID, M_WDATA, M_WSTRB, M_WLAST, M_WVALID,
    output M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE,
    output M_ARBURST, M_ARVALID,
    output S_AWREADY, S_WREADY, S_ARREADY,
    input  M_AWREADY, M_WREADY, M_ARREADY,
    input  S_AWID, S_AWADDR, S_AWLEN, S_AWSIZE,
    input  S_AWBURST, S_AWVALID,
    input  S_WID, S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
    input  S_ARID, S_ARADDR, S_ARLEN, S_ARSIZE,
    input  S_ARBURST, S_ARVALID,
    input  WQ_FULL
  );
endinterface

// File: rtl/axi_m2s_mn.sv
// axi_m2s_mn: N-master to 1-slave AXI request mux with
// round-robin AW/AR grants and AW-ordered W routing.
module axi_m2s_mn_arb #(
  parameter int N     = 4,
  parameter int W_IDX = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  input  logic             hs_i,
  output logic             lock_o,
  output logic [W_IDX-1:0] grant_o
);
  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

  arb_state_e       state_q;
  logic [W_IDX-1:0] g_q;
  logic [W_IDX-1:0] p_q;
  logic [W_IDX-1:0] pick_d;
  logic [W_IDX-1:0] p_d;
  logic             any_d;
  int               idx;

  // First requester scanning p, p+1, ... mod N
  always_comb begin
    pick_d = '0;
    any_d  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(p_q) + k;
      if (idx >= N) idx = idx - N;
      if (!any_d && req_i[W_IDX'(idx)]) begin
        any_d  = 1'b1;
        pick_d = W_IDX'(idx);
      end
    end
  end

  always_comb begin
    p_d = g_q + W_IDX'(1);
    if (g_q == W_IDX'(N-1)) p_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      g_q     <= '0;
      p_q     <= '0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (en_i && any_d) begin
            g_q     <= pick_d;
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (hs_i) begin
            p_q     <= p_d;
            state_q <= ARB_IDLE;
          end
        end
      endcase
    end
  end

  assign lock_o  = (state_q == ARB_LOCKED);
  assign grant_o = g_q;
endmodule

module axi_m2s_mn #(
  parameter int NUM_MASTER  = 4,
  parameter int W_MIDX      = 2,
  parameter int W_ID        = 4,
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int W_STRB      = W_DATA/8,
  parameter int W_SID       = W_MIDX+W_ID,
  parameter logic [W_ADDR-1:0] ADDR_BASE = '0,
  parameter int ADDR_LENGTH = 12,
  parameter int WQ_DEPTH    = 4
) (
  input logic          AXI_CLK,
  input logic          AXI_RSTn,
  axi_m2s_mn_if.slave  bus
);
  localparam int W_TAG = W_ADDR - ADDR_LENGTH;
  localparam int W_PTR = $clog2(WQ_DEPTH);
  localparam logic [W_TAG-1:0] BASE_TAG =
    ADDR_BASE[W_ADDR-1:ADDR_LENGTH];

  logic [NUM_MASTER-1:0] aw_req;
  logic [NUM_MASTER-1:0] ar_req;
  logic                  aw_lock;
  logic                  ar_lock;
  logic [W_MIDX-1:0]     aw_g;
  logic [W_MIDX-1:0]     ar_g;
  logic                  aw_hs;
  logic                  ar_hs;

  logic [W_MIDX-1:0] wq_mem_q [WQ_DEPTH];
  logic [W_PTR-1:0]  wq_wr_q;
  logic [W_PTR-1:0]  wq_rd_q;
  logic [W_PTR:0]    wq_cnt_q;
  logic [W_PTR:0]    wq_cnt_d;
  logic              wq_full_q;
  logic              wq_vld;
  logic [W_MIDX-1:0] wq_head;
  logic              wq_pop;

  always_comb begin
    aw_req = '0;
    ar_req = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      aw_req[i] = bus.M_AWVALID[i] &&
        (bus.M_AWADDR[i*W_ADDR+ADDR_LENGTH +: W_TAG] == BASE_TAG);
      ar_req[i] = bus.M_ARVALID[i] &&
        (bus.M_ARADDR[i*W_ADDR+ADDR_LENGTH +: W_TAG] == BASE_TAG);
    end
  end

  // A full queue blocks new AW grants so every accepted AW has a slot
  axi_m2s_mn_arb #(.N(NUM_MASTER), .W_IDX(W_MIDX)) u_aw_arb (
    .clk_i   (AXI_CLK),
    .rst_ni  (AXI_RSTn),
    .req_i   (aw_req),
    .en_i    (!wq_full_q),
    .hs_i    (aw_hs),
    .lock_o  (aw_lock),
    .grant_o (aw_g)
  );

  axi_m2s_mn_arb #(.N(NUM_MASTER), .W_IDX(W_MIDX)) u_ar_arb (
    .clk_i   (AXI_CLK),
    .rst_ni  (AXI_RSTn),
    .req_i   (ar_req),
    .en_i    (1'b1),
    .hs_i    (ar_hs),
    .lock_o  (ar_lock),
    .grant_o (ar_g)
  );

  assign aw_hs = aw_lock & bus.M_AWVALID[aw_g] & bus.S_AWREADY;
  assign ar_hs = ar_lock & bus.M_ARVALID[ar_g] & bus.S_ARREADY;

  always_comb begin
    bus.S_AWID    = '0;
    bus.S_AWADDR  = '0;
    bus.S_AWLEN   = '0;
    bus.S_AWSIZE  = '0;
    bus.S_AWBURST = '0;
    bus.S_AWVALID = 1'b0;
    bus.M_AWREADY = '0;
    if (aw_lock) begin
      bus.S_AWID    = W_SID'({aw_g,
                        bus.M_AWID[int'(aw_g)*W_ID +: W_ID]});
      bus.S_AWADDR  = bus.M_AWADDR[int'(aw_g)*W_ADDR +: W_ADDR];
      bus.S_AWLEN   = bus.M_AWLEN[int'(aw_g)*8 +: 8];
      bus.S_AWSIZE  = bus.M_AWSIZE[int'(aw_g)*3 +: 3];
      bus.S_AWBURST = bus.M_AWBURST[int'(aw_g)*2 +: 2];
      bus.S_AWVALID = bus.M_AWVALID[aw_g];
      bus.M_AWREADY[aw_g] = bus.S_AWREADY;
    end
  end

  always_comb begin
    bus.S_ARID    = '0;
    bus.S_ARADDR  = '0;
    bus.S_ARLEN   = '0;
    bus.S_ARSIZE  = '0;
    bus.S_ARBURST = '0;
    bus.S_ARVALID = 1'b0;
    bus.M_ARREADY = '0;
    if (ar_lock) begin
      bus.S_ARID    = W_SID'({ar_g,
                        bus.M_ARID[int'(ar_g)*W_ID +: W_ID]});
      bus.S_ARADDR  = bus.M_ARADDR[int'(ar_g)*W_ADDR +: W_ADDR];
      bus.S_ARLEN   = bus.M_ARLEN[int'(ar_g)*8 +: 8];
      bus.S_ARSIZE  = bus.M_ARSIZE[int'(ar_g)*3 +: 3];
      bus.S_ARBURST = bus.M_ARBURST[int'(ar_g)*2 +: 2];
      bus.S_ARVALID = bus.M_ARVALID[ar_g];
      bus.M_ARREADY[ar_g] = bus.S_ARREADY;
    end
  end

  assign wq_vld  = (wq_cnt_q != '0);
  assign wq_head = wq_mem_q[wq_rd_q];
  assign wq_pop  = wq_vld & bus.M_WVALID[wq_head]
                 & bus.S_WREADY & bus.M_WLAST[wq_head];

  always_comb begin
    wq_cnt_d = wq_cnt_q;
    unique case ({aw_hs, wq_pop})
      2'b10:   wq_cnt_d = wq_cnt_q + (W_PTR+1)'(1);
      2'b01:   wq_cnt_d = wq_cnt_q - (W_PTR+1)'(1);
      default: wq_cnt_d = wq_cnt_q;
    endcase
  end

  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      wq_wr_q   <= '0;
      wq_rd_q   <= '0;
      wq_cnt_q  <= '0;
      wq_full_q <= 1'b0;
      for (int k = 0; k < WQ_DEPTH; k++) wq_mem_q[k] <= '0;
    end else begin
      if (aw_hs) begin
        wq_mem_q[wq_wr_q] <= aw_g;
        wq_wr_q           <= wq_wr_q + W_PTR'(1);
      end
      if (wq_pop) wq_rd_q <= wq_rd_q + W_PTR'(1);
      wq_cnt_q  <= wq_cnt_d;
      wq_full_q <= (wq_cnt_d == (W_PTR+1)'(WQ_DEPTH));
    end
  end

  assign bus.WQ_FULL = wq_full_q;

  // W beats only ever come from the master at the queue head
  always_comb begin
    bus.S_WID    = '0;
    bus.S_WDATA  = '0;
    bus.S_WSTRB  = '0;
    bus.S_WLAST  = 1'b0;
    bus.S_WVALID = 1'b0;
    bus.M_WREADY = '0;
    if (wq_vld) begin
      bus.S_WID    = W_SID'({wq_head,
                       bus.M_WID[int'(wq_head)*W_ID +: W_ID]});
      bus.S_WDATA  = bus.M_WDATA[int'(wq_head)*W_DATA +: W_DATA];
      bus.S_WSTRB  = bus.M_WSTRB[int'(wq_head)*W_STRB +: W_STRB];
      bus.S_WLAST  = bus.M_WLAST[wq_head];
      bus.S_WVALID = bus.M_WVALID[wq_head];
      bus.M_WREADY[wq_head] = bus.S_WREADY;
    end
  end
endmodule

// File: tb/tb_axi_m2s_mn.sv
// tb_axi_m2s_mn: directed bench for axi_m2s_mn, 4 masters,
// slave window 0x1000-0x1FFF, 4-entry write-order queue.
module tb_axi_m2s_mn;
  localparam int NM = 4;

  logic AXI_CLK  = 1'b0;
  logic AXI_RSTn = 1'b0;
  int   total    = 0;
  int   bad      = 0;

  axi_m2s_mn_if #(
    .NUM_MASTER(NM), .W_MIDX(2), .W_ID(4),
    .W_ADDR(32), .W_DATA(32)
  ) bus ();

  axi_m2s_mn #(
    .NUM_MASTER(NM), .W_MIDX(2), .W_ID(4),
    .W_ADDR(32), .W_DATA(32),
    .ADDR_BASE(32'h1000), .ADDR_LENGTH(12), .WQ_DEPTH(4)
  ) dut (
    .AXI_CLK  (AXI_CLK),
    .AXI_RSTn (AXI_RSTn),
    .bus      (bus)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge AXI_CLK);
  endtask

  task automatic aw(input int i, input logic v,
                    input logic [31:0] a, input logic [3:0] id,
                    input logic [7:0] len);
    bus.M_AWVALID[i]        = v;
    bus.M_AWADDR[i*32 +: 32] = a;
    bus.M_AWID[i*4 +: 4]     = id;
    bus.M_AWLEN[i*8 +: 8]    = len;
  endtask

  task automatic ar(input int i, input logic v,
                    input logic [31:0] a, input logic [3:0] id);
    bus.M_ARVALID[i]         = v;
    bus.M_ARADDR[i*32 +: 32] = a;
    bus.M_ARID[i*4 +: 4]     = id;
  endtask

  task automatic w(input int i, input logic v, input logic l,
                   input logic [31:0] d, input logic [3:0] id);
    bus.M_WVALID[i]         = v;
    bus.M_WLAST[i]          = l;
    bus.M_WDATA[i*32 +: 32] = d;
    bus.M_WID[i*4 +: 4]     = id;
    bus.M_WSTRB[i*4 +: 4]   = 4'hF;
  endtask

  initial begin
    bus.M_AWID = '0; bus.M_AWADDR = '0; bus.M_AWLEN = '0;
    bus.M_AWSIZE = '0; bus.M_AWBURST = '0; bus.M_AWVALID = '0;
    bus.M_WID = '0; bus.M_WDATA = '0; bus.M_WSTRB = '0;
    bus.M_WLAST = '0; bus.M_WVALID = '0;
    bus.M_ARID = '0; bus.M_ARADDR = '0; bus.M_ARLEN = '0;
    bus.M_ARSIZE = '0; bus.M_ARBURST = '0; bus.M_ARVALID = '0;
    bus.S_AWREADY = 1'b0; bus.S_WREADY = 1'b0;
    bus.S_ARREADY = 1'b0;

    smp();
    chk("rst_awvalid", bus.S_AWVALID, 0);
    chk("rst_wvalid", bus.S_WVALID, 0);
    chk("rst_arvalid", bus.S_ARVALID, 0);
    chk("rst_readies", {bus.M_AWREADY, bus.M_WREADY,
                        bus.M_ARREADY}, 0);
    chk("rst_awaddr", bus.S_AWADDR, 0);
    chk("rst_wqfull", bus.WQ_FULL, 0);
    tick();
    AXI_RSTn = 1'b1;

    // cycle 0: masters 0,1,3 request, slave always ready
    aw(0, 1'b1, 32'h1000, 4'h1, 8'h10);
    aw(1, 1'b1, 32'h1100, 4'h2, 8'h11);
    aw(3, 1'b1, 32'h1300, 4'h4, 8'h13);
    bus.S_AWREADY = 1'b1;
    smp(); chk("rr_c0_valid", bus.S_AWVALID, 0);
    tick(); smp();
    chk("rr_c1_valid", bus.S_AWVALID, 1);
    chk("rr_c1_id", bus.S_AWID, 6'h01);
    chk("rr_c1_addr", bus.S_AWADDR, 32'h1000);
    chk("rr_c1_len", bus.S_AWLEN, 8'h10);
    chk("rr_c1_ready", bus.M_AWREADY, 4'b0001);
    tick(); smp();
    chk("rr_c2_valid", bus.S_AWVALID, 0);
    tick(); smp();
    chk("rr_c3_id", bus.S_AWID, 6'h12);
    chk("rr_c3_len", bus.S_AWLEN, 8'h11);
    tick(); tick(); smp();
    chk("rr_c5_id", bus.S_AWID, 6'h34);
    chk("rr_c5_ready", bus.M_AWREADY, 4'b1000);
    tick(); tick(); smp();
    chk("rr_c7_id", bus.S_AWID, 6'h01);
    chk("rr_c7_full", bus.WQ_FULL, 0);
    tick(); smp();
    chk("full_c8_flag", bus.WQ_FULL, 1);
    chk("full_c8_valid", bus.S_AWVALID, 0);
    tick(); smp();
    chk("full_c9_valid", bus.S_AWVALID, 0);
    tick();

    // cycle 10: single-beat burst from master 0 pops one entry
    w(0, 1'b1, 1'b1, 32'h55, 4'h2);
    bus.S_WREADY = 1'b1;
    smp();
    chk("pop_c10_wvalid", bus.S_WVALID, 1);
    chk("pop_c10_wid", bus.S_WID, 6'h02);
    chk("pop_c10_wdata", bus.S_WDATA, 32'h55);
    chk("pop_c10_wstrb", bus.S_WSTRB, 4'hF);
    chk("pop_c10_wready", bus.M_WREADY, 4'b0001);
    chk("pop_c10_awvalid", bus.S_AWVALID, 0);
    tick();
    w(0, 1'b0, 1'b0, 32'h0, 4'h2);
    smp();
    chk("pop_c11_awvalid", bus.S_AWVALID, 0);
    chk("pop_c11_full", bus.WQ_FULL, 0);
    tick(); smp();
    chk("pop_c12_awvalid", bus.S_AWVALID, 1);
    chk("pop_c12_id", bus.S_AWID, 6'h12);
    tick();

    // cycle 13: queue holds 1,3,0,1; master 0 offers W early
    bus.M_AWVALID = '0;
    w(0, 1'b1, 1'b1, 32'h66, 4'h2);
    smp();
    chk("wo_c13_wvalid", bus.S_WVALID, 0);
    chk("wo_c13_wready", bus.M_WREADY, 4'b0010);
    chk("wo_c13_full", bus.WQ_FULL, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      w(1, 1'b1, (k == 3), 32'hA0 + k, 4'h7);
      smp();
      chk("wo_m1_wvalid", bus.S_WVALID, 1);
      chk("wo_m1_wid", bus.S_WID, 6'h17);
      chk("wo_m1_wdata", bus.S_WDATA, 32'hA0 + k);
      chk("wo_m1_wlast", bus.S_WLAST, (k == 3));
      chk("wo_m1_wready", bus.M_WREADY, 4'b0010);
      tick();
    end
    w(1, 1'b0, 1'b0, 32'h0, 4'h7);
    w(3, 1'b1, 1'b1, 32'hD3, 4'h9);
    smp();
    chk("wo_m3_wid", bus.S_WID, 6'h39);
    chk("wo_m3_wdata", bus.S_WDATA, 32'hD3);
    tick();
    w(3, 1'b0, 1'b0, 32'h0, 4'h9);
    smp();
    chk("wo_m0_wid", bus.S_WID, 6'h02);
    chk("wo_m0_wdata", bus.S_WDATA, 32'h66);
    chk("wo_m0_wready", bus.M_WREADY, 4'b0001);
    tick();

    // cycle 20: backpressure with master 2 granted (p=2)
    w(0, 1'b0, 1'b0, 32'h0, 4'h2);
    aw(2, 1'b1, 32'h1200, 4'h5, 8'h00);
    aw(0, 1'b1, 32'h1004, 4'h6, 8'h00);
    bus.S_AWREADY = 1'b0;
    smp(); chk("bp_c20_valid", bus.S_AWVALID, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("bp_hold_valid", bus.S_AWVALID, 1);
      chk("bp_hold_id", bus.S_AWID, 6'h25);
      chk("bp_hold_addr", bus.S_AWADDR, 32'h1200);
      chk("bp_hold_ready", bus.M_AWREADY, 4'b0000);
      tick();
    end
    bus.S_AWREADY = 1'b1;
    smp();
    chk("bp_hs_ready", bus.M_AWREADY, 4'b0100);
    tick();
    bus.M_AWVALID[2] = 1'b0;
    smp(); chk("bp_idle_valid", bus.S_AWVALID, 0);
    tick(); smp();
    chk("bp_next_id", bus.S_AWID, 6'h06);
    chk("bp_next_addr", bus.S_AWADDR, 32'h1004);
    tick();

    // cycle 29: AW from master 3 stalls, W burst from master 1
    bus.M_AWVALID[0] = 1'b0;
    aw(3, 1'b1, 32'h1300, 4'h8, 8'h03);
    bus.S_AWREADY = 1'b0;
    w(1, 1'b1, 1'b0, 32'hC0, 4'h7);
    smp();
    chk("mr_c29_wdata", bus.S_WDATA, 32'hC0);
    chk("mr_c29_awvalid", bus.S_AWVALID, 0);
    tick();
    w(1, 1'b1, 1'b0, 32'hC1, 4'h7);
    smp();
    chk("mr_pre_awvalid", bus.S_AWVALID, 1);
    chk("mr_pre_awid", bus.S_AWID, 6'h38);
    chk("mr_pre_wvalid", bus.S_WVALID, 1);
    chk("mr_pre_wdata", bus.S_WDATA, 32'hC1);
    #1 AXI_RSTn = 1'b0;
    #1;
    chk("mr_awvalid", bus.S_AWVALID, 0);
    chk("mr_wvalid", bus.S_WVALID, 0);
    chk("mr_arvalid", bus.S_ARVALID, 0);
    chk("mr_readies", {bus.M_AWREADY, bus.M_WREADY,
                       bus.M_ARREADY}, 0);
    chk("mr_awid", bus.S_AWID, 0);
    chk("mr_wdata", bus.S_WDATA, 0);
    chk("mr_full", bus.WQ_FULL, 0);

    // after release: p=0 picks 0 over 3; master 2 AW misses window
    aw(0, 1'b1, 32'h1000, 4'h1, 8'h00);
    aw(2, 1'b1, 32'h2000, 4'h3, 8'h00);
    ar(2, 1'b1, 32'h1FFC, 4'h4);
    bus.S_ARREADY = 1'b1;
    tick(); tick();
    AXI_RSTn = 1'b1;
    smp();
    chk("pr_wvalid", bus.S_WVALID, 0);
    chk("pr_wready", bus.M_WREADY, 4'b0000);
    chk("pr_awvalid", bus.S_AWVALID, 0);
    tick();
    bus.S_AWREADY = 1'b1;
    smp();
    chk("pr_awid", bus.S_AWID, 6'h01);
    chk("pr_awready", bus.M_AWREADY, 4'b0001);
    chk("dec_arvalid", bus.S_ARVALID, 1);
    chk("dec_arid", bus.S_ARID, 6'h24);
    chk("dec_araddr", bus.S_ARADDR, 32'h1FFC);
    chk("dec_arready", bus.M_ARREADY, 4'b0100);
    tick();
    bus.M_AWVALID[0] = 1'b0;
    bus.M_AWVALID[3] = 1'b0;
    ar(2, 1'b0, 32'h1FFC, 4'h4);
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("dec_miss_valid", bus.S_AWVALID, 0);
      chk("dec_miss_ready", bus.M_AWREADY, 4'b0000);
      tick();
    end
    smp();
    chk("dec_ar_idle", bus.S_ARVALID, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
